idct_stage2: RTL and testbench
==============================

IDCT_STAGE2 -- requirements
Module: idct_stage2

Interface
REQ-001 SHALL have parameter DW, default 16: signed sample width of every input and output lane.
REQ-002 SHALL have parameter FRAC, default 14: fractional bits of the rotation coefficients (Q1.FRAC).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports N0..N7, input, DW bits each: forward-stage2 coefficients of one row.
REQ-006 SHALL have port in_valid, input, 1 bit: the N lanes hold a valid row.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a row this cycle.
REQ-008 SHALL have ports M0..M7, output, DW bits each: reconstructed stage1 lanes.
REQ-009 SHALL have port out_valid, output, 1 bit: the M lanes hold a valid row.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream block accepts a row.
REQ-011 SHALL have port out_last, output, 1 bit: the current output row is row 7 of an 8-row block.

Function
REQ-012 SHALL accept a row when in_valid and in_ready are both high in the same cycle.
REQ-013 SHALL invert the even butterfly:
- M0 = (N0+N3)/2, M3 = (N0-N3)/2
- M1 = (N1+N2)/2, M2 = (N1-N2)/2
- each sum is formed at DW+1 bits.
REQ-014 SHALL invert the odd rotations:
- M4 = c3*N4 - s3*N7, M7 = s3*N4 + c3*N7
- M5 = c1*N5 - s1*N6, M6 = s1*N5 + c1*N6
- constants (Q1.14): c1=16069, s1=3196, c3=13623, s3=9102
- products are full width; sums are held at 2*DW+1 bits and then scaled by >>FRAC.
REQ-015 SHALL saturate every output lane to the signed DW range: [-32768, 32767] at the defaults.
REQ-016 SHALL be a 3-stage pipeline:
- S1 registers the inputs.
- S2 forms the products and the even sums.
- S3 forms the odd sums, scales, rounds and saturates into the M registers.
REQ-017 SHALL raise out_valid 3 cycles after a row is accepted, provided no stall occurs in between.
REQ-018 SHALL define stall = out_valid & ~out_ready and SHALL drive in_ready = ~stall.
REQ-019 SHALL, while stall is high:
- freeze all stage data and valid bits
- hold M0..M7 and out_last stable.
REQ-020 SHALL, when stall is low, advance every stage by one; a stage with its valid bit low propagates a bubble.
REQ-021 SHALL leave the data registers of an invalid stage don't-care, with out_valid low for that slot.
REQ-022 SHALL keep a 3-bit row counter:
- increments on each output handshake (out_valid & out_ready)
- wraps from 7 to 0
- out_last = out_valid & (counter == 7).
REQ-023 SHALL sustain a throughput of one row per cycle while out_ready stays high.

Reset
REQ-024 SHALL, while reset is low, clear all stage valid bits, out_valid, out_last, the row counter and M0..M7 to 0.
REQ-025 SHALL discard any in-flight rows when reset is asserted mid-operation; no partial row is emitted afterwards.
REQ-026 SHALL drive in_ready high in the first cycle after reset is released.

Configuration
REQ-027 SHALL, when macro IDCT_STAGE2_ROUND_EN is defined, round half-up at every right shift (>>1 and >>FRAC) by adding 2^(shift-1) before shifting.
REQ-028 SHALL, when IDCT_STAGE2_ROUND_EN is undefined, use a plain arithmetic-shift truncation toward minus infinity at every right shift.

Structure
REQ-029 SHALL place the following in a shared package idct_pkg, for reuse by the other IDCT stages:
- the coefficient constants (c1, s1, c3, s3)
- FRAC
- a saturate-to-DW function.
REQ-030 SHALL implement the two identical odd rotations as one sub-module, idct_rot, instantiated twice with coefficient parameters.

Verification
REQ-031 SHALL cover even path, ROUND_EN undefined: N0=100, N3=20 -> M0=60, M3=40 after 3 cycles with out_valid high.
REQ-032 SHALL cover rotation: N4=16384, N7=0 -> M4=13623, M7=9102; N5=16384, N6=0 -> M5=16069, M6=3196.
REQ-033 SHALL cover saturation and rounding:
- N4=32767, N7=-32768 -> M4=32767 (saturated)
- N0=-3, N3=0 -> M0=-2 without IDCT_STAGE2_ROUND_EN, -1 with it.
REQ-034 SHALL cover backpressure: 10 back-to-back rows with out_ready low for cycles 4-7 -> in_ready low exactly while stall is high, all 10 rows out in order with no loss or duplication, and M held stable during the stall.
REQ-035 SHALL cover block framing: 16 rows -> out_last high on output rows 7 and 15 only.
REQ-036 SHALL cover reset mid-stream: assert reset with 2 rows in flight -> out_valid=0 and counter=0 after release, the next row emerges 3 cycles after acceptance, and out_last first appears on its 8th row.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared constants and helpers for the IDCT stages.
// IDCT_STAGE2_ROUND_EN selects half-up rounding on every right shift.
package idct_pkg;

  localparam int unsigned FRAC = 14;
  localparam int unsigned CW   = 16;

  // Q1.14 rotation coefficients
  localparam int C1 = 16069;
  localparam int S1 = 3196;
  localparam int C3 = 13623;
  localparam int S3 = 9102;

`ifdef IDCT_STAGE2_ROUND_EN
  localparam bit RoundEn = 1'b1;
`else
  localparam bit RoundEn = 1'b0;
`endif

  // Clip a sign-extended value to the signed range of a dw-bit lane.
  function automatic logic signed [63:0] sat_dw(input logic signed [63:0] v,
                                                input int unsigned dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/idct_rot.sv
// Inverse odd rotation: x = C*a - S*b, y = S*a + C*b, scaled by >>FRAC and saturated.
// Products are registered; sums and scaling are combinational. Rounding follows
// IDCT_STAGE2_ROUND_EN.
module idct_rot #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = idct_pkg::FRAC,
  parameter int          Cos  = idct_pkg::C3,
  parameter int          Sin  = idct_pkg::S3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic signed [DW-1:0] a_i,
  input  logic signed [DW-1:0] b_i,
  output logic signed [DW-1:0] x_o,
  output logic signed [DW-1:0] y_o
);
  import idct_pkg::*;

  localparam int unsigned PW = DW + CW;
  localparam int unsigned SW = PW + 1;
  localparam logic signed [PW-1:0] CosW = PW'(Cos);
  localparam logic signed [PW-1:0] SinW = PW'(Sin);
  localparam logic signed [SW-1:0] Rnd  = RoundEn ? (SW'(1) <<< (FRAC - 1)) : '0;

  logic signed [PW-1:0] p_ac_q, p_bs_q, p_as_q, p_bc_q;
  logic signed [SW-1:0] sx, sy;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p_ac_q <= '0;
      p_bs_q <= '0;
      p_as_q <= '0;
      p_bc_q <= '0;
    end else if (en_i) begin
      p_ac_q <= PW'(a_i) * CosW;
      p_bs_q <= PW'(b_i) * SinW;
      p_as_q <= PW'(a_i) * SinW;
      p_bc_q <= PW'(b_i) * CosW;
    end
  end

  always_comb begin
    sx  = (SW'(p_ac_q) - SW'(p_bs_q) + Rnd) >>> FRAC;
    sy  = (SW'(p_as_q) + SW'(p_bc_q) + Rnd) >>> FRAC;
    x_o = DW'(sat_dw(64'(sx), DW));
    y_o = DW'(sat_dw(64'(sy), DW));
  end

endmodule

// File: rtl/idct_stage2.sv
// Inverse of forward stage 2: even butterfly halving plus two odd rotations, 3-stage
// pipeline with global stall and 8-row framing. IDCT_STAGE2_ROUND_EN enables rounding.
module idct_stage2 #(
  parameter int unsigned DW   = 16,
  parameter int unsigned FRAC = idct_pkg::FRAC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] N0,
  input  logic [DW-1:0] N1,
  input  logic [DW-1:0] N2,
  input  logic [DW-1:0] N3,
  input  logic [DW-1:0] N4,
  input  logic [DW-1:0] N5,
  input  logic [DW-1:0] N6,
  input  logic [DW-1:0] N7,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] M0,
  output logic [DW-1:0] M1,
  output logic [DW-1:0] M2,
  output logic [DW-1:0] M3,
  output logic [DW-1:0] M4,
  output logic [DW-1:0] M5,
  output logic [DW-1:0] M6,
  output logic [DW-1:0] M7,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);
  import idct_pkg::*;

  localparam int unsigned EW = DW + 1;
  localparam logic signed [EW:0] HalfRnd = RoundEn ? (EW + 1)'(1) : '0;

  logic                 stall, adv;
  logic                 v1_q, v2_q, v3_q;
  logic [2:0]           cnt_q;
  logic signed [DW-1:0] n_in [8];
  logic signed [DW-1:0] n_q  [8];
  logic signed [EW-1:0] e_q  [4];  // N0+N3, N0-N3, N1+N2, N1-N2
  logic signed [DW-1:0] m_q  [8];
  logic signed [DW-1:0] r4, r5, r6, r7;

  function automatic logic signed [DW-1:0] half_sat(input logic signed [EW-1:0] e);
    logic signed [EW:0] t;
    t = ((EW + 1)'(e) + HalfRnd) >>> 1;
    return DW'(sat_dw(64'(t), DW));
  endfunction

  assign n_in[0] = N0;
  assign n_in[1] = N1;
  assign n_in[2] = N2;
  assign n_in[3] = N3;
  assign n_in[4] = N4;
  assign n_in[5] = N5;
  assign n_in[6] = N6;
  assign n_in[7] = N7;

  // The whole pipeline freezes while the output row is refused.
  assign stall    = v3_q & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      for (int i = 0; i < 8; i++) n_q[i] <= '0;
      for (int i = 0; i < 4; i++) e_q[i] <= '0;
    end else if (adv) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      if (in_valid) begin
        for (int i = 0; i < 8; i++) n_q[i] <= n_in[i];
      end
      if (v1_q) begin
        e_q[0] <= EW'(n_q[0]) + EW'(n_q[3]);
        e_q[1] <= EW'(n_q[0]) - EW'(n_q[3]);
        e_q[2] <= EW'(n_q[1]) + EW'(n_q[2]);
        e_q[3] <= EW'(n_q[1]) - EW'(n_q[2]);
      end
    end
  end

  idct_rot #(.DW(DW), .FRAC(FRAC), .Cos(C3), .Sin(S3)) u_rot3 (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (adv & v1_q),
    .a_i    (n_q[4]),
    .b_i    (n_q[7]),
    .x_o    (r4),
    .y_o    (r7)
  );

  idct_rot #(.DW(DW), .FRAC(FRAC), .Cos(C1), .Sin(S1)) u_rot1 (
    .clk_i  (clk),
    .rst_ni (reset),
    .en_i   (adv & v1_q),
    .a_i    (n_q[5]),
    .b_i    (n_q[6]),
    .x_o    (r5),
    .y_o    (r6)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3_q <= 1'b0;
      for (int i = 0; i < 8; i++) m_q[i] <= '0;
    end else if (adv) begin
      v3_q <= v2_q;
      if (v2_q) begin
        m_q[0] <= half_sat(e_q[0]);
        m_q[1] <= half_sat(e_q[2]);
        m_q[2] <= half_sat(e_q[3]);
        m_q[3] <= half_sat(e_q[1]);
        m_q[4] <= r4;
        m_q[5] <= r5;
        m_q[6] <= r6;
        m_q[7] <= r7;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 3'd0;
    end else if (v3_q && out_ready) begin
      cnt_q <= cnt_q + 3'd1;
    end
  end

  assign out_valid = v3_q;
  assign out_last  = v3_q & (cnt_q == 3'd7);

  assign M0 = m_q[0];
  assign M1 = m_q[1];
  assign M2 = m_q[2];
  assign M3 = m_q[3];
  assign M4 = m_q[4];
  assign M5 = m_q[5];
  assign M6 = m_q[6];
  assign M7 = m_q[7];

endmodule

// File: tb/tb_idct_stage2.sv
// Self-checking bench for idct_stage2: directed vectors, backpressure, framing,
// mid-stream reset and random traffic against an arithmetic reference model.
module tb_idct_stage2;

  typedef logic [7:0][15:0] row_t;
  typedef struct {
    row_t m;
    int   cyc;
    int   stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready;
  row_t        nin;
  logic        in_ready, out_valid, out_last;
  logic [15:0] mo [8];

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   stall_cnt = 0;
  int   out_cnt = 0;

  always #5 clk = ~clk;

  idct_stage2 #(.DW(16), .FRAC(14)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .N0        (nin[0]),
    .N1        (nin[1]),
    .N2        (nin[2]),
    .N3        (nin[3]),
    .N4        (nin[4]),
    .N5        (nin[5]),
    .N6        (nin[6]),
    .N7        (nin[7]),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M0        (mo[0]),
    .M1        (mo[1]),
    .M2        (mo[2]),
    .M3        (mo[3]),
    .M4        (mo[4]),
    .M5        (mo[5]),
    .M6        (mo[6]),
    .M7        (mo[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  // floor((x + rounding) / 2^sh)
  function automatic longint shr(input longint x, input int sh);
`ifdef IDCT_STAGE2_ROUND_EN
    x = x + (longint'(1) << (sh - 1));
`endif
    return x >>> sh;
  endfunction

  function automatic longint sat16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic row_t model(input row_t n);
    longint v [8];
    row_t   m;
    for (int i = 0; i < 8; i++) v[i] = longint'($signed(n[i]));
    m[0] = 16'(sat16(shr(v[0] + v[3], 1)));
    m[3] = 16'(sat16(shr(v[0] - v[3], 1)));
    m[1] = 16'(sat16(shr(v[1] + v[2], 1)));
    m[2] = 16'(sat16(shr(v[1] - v[2], 1)));
    m[4] = 16'(sat16(shr(13623 * v[4] - 9102 * v[7], 14)));
    m[7] = 16'(sat16(shr(9102 * v[4] + 13623 * v[7], 14)));
    m[5] = 16'(sat16(shr(16069 * v[5] - 3196 * v[6], 14)));
    m[6] = 16'(sat16(shr(3196 * v[5] + 16069 * v[6], 14)));
    return m;
  endfunction

  function automatic row_t rand_row();
    row_t r;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       r[i] = 16'h7fff;
        1:       r[i] = 16'h8000;
        default: r[i] = 16'($urandom);
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // One clock cycle: sample at negedge against the scoreboard, then advance.
  task automatic step(output bit acc);
    bit   stall;
    exp_t e;
    acc = 1'b0;
    @(negedge clk);
    stall = out_valid && !out_ready;
    check("in_ready", in_ready, !stall);
    if (out_valid) begin
      if (q.size() == 0) begin
        check("spurious_row", out_valid, 1'b0);
      end else begin
        e = q[0];
        for (int i = 0; i < 8; i++) check($sformatf("M%0d", i), mo[i], e.m[i]);
        check("out_last", out_last, out_cnt == 7);
        if (out_ready) begin
          check("latency", cyc - e.cyc, 3 + stall_cnt - e.stalls);
          void'(q.pop_front());
          out_cnt = (out_cnt + 1) % 8;
        end
      end
    end else begin
      check("out_last_idle", out_last, 1'b0);
    end
    if (stall) stall_cnt++;
    if (in_valid && in_ready) begin
      acc      = 1'b1;
      e.m      = model(nin);
      e.cyc    = cyc;
      e.stalls = stall_cnt;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input row_t r);
    bit acc;
    nin      = r;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) step(acc);
    check("accept_timeout", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40 && q.size() != 0; k++) step(acc);
    check("drain_left", q.size(), 0);
    for (int k = 0; k < 3; k++) step(acc);
  endtask

  initial begin
    row_t r;
    row_t bp [10];
    bit   acc;
    int   idx;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nin       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("rst_M%0d", i), mo[i], 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Directed vectors: even path, rotations, saturation, rounding of -3/2
    r = '0; r[0] = 16'd100; r[3] = 16'd20; send(r);
    r = '0; r[4] = 16'd16384; r[5] = 16'd16384; send(r);
    r = '0; r[4] = 16'h7fff; r[7] = 16'h8000; send(r);
    r = '0; r[0] = 16'hfffd; send(r);
    drain();

    // Backpressure: 10 back-to-back rows, out_ready low in cycles 4..7
    for (int i = 0; i < 10; i++) bp[i] = rand_row();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (idx < 10);
      if (idx < 10) nin = bp[idx];
      step(acc);
      if (acc) idx++;
    end
    check("bp_rows_sent", idx, 10);
    drain();

    // Reset with two rows in flight, then a 16-row block
    in_valid = 1'b1;
    nin = rand_row(); step(acc);
    nin = rand_row(); step(acc);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_M0", mo[0], 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    out_cnt = 0;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 1'b0);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_last", out_last, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 4; k++) step(acc);
    for (int k = 0; k < 16; k++) send(rand_row());
    drain();

    // Random traffic with random backpressure
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      nin       = rand_row();
      step(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
